// File: rtl/rf_wport_arb.sv
// Write-port arbiter for the register file. Pipeline writeback always wins.
// Aux writes are queued in a small FIFO and drain in idle port cycles.
// A pipe write to R kills queued aux entries for R. A starvation timer raises
// stall_req when the queue head is left unserved for too long.
module rf_wport_arb #(
  parameter int AUX_DEPTH  = 2,
  parameter int STARVE_MAX = 8,
  parameter int DW         = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pipe_we,
  input  logic [4:0]                   pipe_wr,
  input  logic [DW-1:0]                pipe_wd,
  input  logic                         aux_valid,
  output logic                         aux_ready,
  input  logic [4:0]                   aux_wr,
  input  logic [DW-1:0]                aux_wd,
  output logic                         rf_we,
  output logic [4:0]                   rf_wr,
  output logic [DW-1:0]                rf_wd,
  output logic                         stall_req,
  output logic [31:0]                  pend_mask,
  output logic [$clog2(AUX_DEPTH):0]   aux_count
);

  localparam int AW = $clog2(AUX_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_RELOAD = SW'(STARVE_MAX - 1);

  logic [4:0]           q_wr [AUX_DEPTH];
  logic [DW-1:0]        q_wd [AUX_DEPTH];
  logic [AUX_DEPTH-1:0] q_live;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [CW-1:0]        count;
  logic [SW-1:0]        starve_left;

  logic pipe_issue;
  logic fifo_nonempty;
  logic pop;
  logic push;
  logic unserved;

  assign aux_count     = count;
  assign aux_ready     = rst_n & (count < CW'(AUX_DEPTH));
  assign pipe_issue    = pipe_we & (pipe_wr != 5'd0);
  assign fifo_nonempty = (count != '0);
  assign pop           = fifo_nonempty & ~pipe_issue;
  // x0 requests are acknowledged but never stored
  assign push          = aux_valid & aux_ready & (aux_wr != 5'd0);
  assign unserved      = fifo_nonempty & ~pop;

  // FIFO payload storage; contents are only meaningful where q_live/count say so
  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[wr_ptr] <= aux_wr;
      q_wd[wr_ptr] <= aux_wd;
    end
  end

  // FIFO pointers, occupancy and liveness; the push comes last so a same-cycle
  // younger request to a killed register stays live
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_live <= '0;
    end else begin
      if (pipe_issue) begin
        for (int i = 0; i < AUX_DEPTH; i++) begin
          if (q_wr[i] == pipe_wr) q_live[i] <= 1'b0;
        end
      end
      if (pop) begin
        q_live[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + AW'(1);
      end
      if (push) begin
        q_live[wr_ptr] <= 1'b1;
        wr_ptr         <= wr_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered write port; address/data hold their last value when idle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we <= 1'b0;
      rf_wr <= '0;
      rf_wd <= '0;
    end else if (pipe_issue) begin
      rf_we <= 1'b1;
      rf_wr <= pipe_wr;
      rf_wd <= pipe_wd;
    end else if (pop && q_live[rd_ptr]) begin
      rf_we <= 1'b1;
      rf_wr <= q_wr[rd_ptr];
      rf_wd <= q_wd[rd_ptr];
    end else begin
      rf_we <= 1'b0;
    end
  end

  // Starvation down-counter: terminal count reached with the head still unserved
  // raises stall_req, which drops at the edge where the head finally pops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_left <= STARVE_RELOAD;
      stall_req   <= 1'b0;
    end else if (unserved) begin
      if (starve_left == '0) stall_req   <= 1'b1;
      else                   starve_left <= starve_left - SW'(1);
    end else begin
      starve_left <= STARVE_RELOAD;
      stall_req   <= 1'b0;
    end
  end

  // Hazard mask: one-hot destinations of live queued entries, x0 never flagged
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < AUX_DEPTH; i++) begin
      if (q_live[i]) pend_mask[q_wr[i]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb: reset, drain, priority/full, kill,
// starvation, x0 filtering and reset during a pending drain.
module tb_rf_wport_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_wr = '0;
  logic [31:0] pipe_wd = '0;
  logic        aux_valid = 1'b0;
  logic        aux_ready;
  logic [4:0]  aux_wr = '0;
  logic [31:0] aux_wd = '0;
  logic        rf_we;
  logic [4:0]  rf_wr;
  logic [31:0] rf_wd;
  logic        stall_req;
  logic [31:0] pend_mask;
  logic [1:0]  aux_count;

  int total = 0;
  int bad   = 0;

  rf_wport_arb #(.AUX_DEPTH(2), .STARVE_MAX(8), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .pipe_we(pipe_we), .pipe_wr(pipe_wr), .pipe_wd(pipe_wd),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_wr(aux_wr), .aux_wd(aux_wd),
    .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
    .stall_req(stall_req), .pend_mask(pend_mask), .aux_count(aux_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_wr = '0; pipe_wd = '0;
    aux_valid = 1'b0; aux_wr = '0; aux_wd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; aux_valid = 1'b1; aux_wr = 5'd4; aux_wd = 32'h44;
    tick(); tick();
    total++; if (aux_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", aux_ready); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%0b exp=0", rf_we); end
    total++; if (aux_count !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", aux_count); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL rst_mask got=%0h exp=0", pend_mask); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0b exp=0", stall_req); end
    idle_inputs();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_idle_drain();
    aux_valid = 1'b1; aux_wr = 5'd5; aux_wd = 32'h1234;
    total++; if (aux_ready !== 1'b1) begin bad++; $display("FAIL drain_ready got=%0b exp=1", aux_ready); end
    tick();
    aux_valid = 1'b0;
    total++; if (pend_mask !== 32'h20) begin bad++; $display("FAIL drain_mask1 got=%0h exp=20", pend_mask); end
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_we0 got=%0b exp=0", rf_we); end
    tick();
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd5, 32'h1234}) begin bad++; $display("FAIL drain_issue got=%0b/%0d/%0h exp=1/5/1234", rf_we, rf_wr, rf_wd); end
    total++; if (pend_mask !== 32'h0) begin bad++; $display("FAIL drain_mask2 got=%0h exp=0", pend_mask); end
    tick();
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b0, 5'd5, 32'h1234}) begin bad++; $display("FAIL drain_hold got=%0b/%0d/%0h exp=0/5/1234", rf_we, rf_wr, rf_wd); end
  endtask

  task automatic test_priority_full();
    pipe_we = 1'b1; pipe_wr = 5'd1; pipe_wd = 32'h1;
    aux_valid = 1'b1; aux_wr = 5'd6; aux_wd = 32'h66;
    tick();
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd1, 32'h1}) begin bad++; $display("FAIL prio_pipe1 got=%0b/%0d/%0h exp=1/1/1", rf_we, rf_wr, rf_wd); end
    pipe_wr = 5'd2; pipe_wd = 32'h2; aux_wr = 5'd7; aux_wd = 32'h77;
    tick();
    total++; if (aux_count !== 2'd2) begin bad++; $display("FAIL prio_count2 got=%0d exp=2", aux_count); end
    total++; if (pend_mask !== 32'hC0) begin bad++; $display("FAIL prio_mask got=%0h exp=c0", pend_mask); end
    pipe_wr = 5'd3; pipe_wd = 32'h3; aux_wr = 5'd8; aux_wd = 32'h88;
    #1;
    total++; if (aux_ready !== 1'b0) begin bad++; $display("FAIL prio_full_ready got=%0b exp=0", aux_ready); end
    tick();
    total++; if ({rf_wr, aux_count} !== {5'd3, 2'd2}) begin bad++; $display("FAIL prio_pipe3 got=%0d/%0d exp=3/2", rf_wr, aux_count); end
    pipe_we = 1'b0; pipe_wr = '0;
    #1;
    total++; if (aux_ready !== 1'b0) begin bad++; $display("FAIL prio_pop_noroom got=%0b exp=0", aux_ready); end
    tick();
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd6, 32'h66}) begin bad++; $display("FAIL prio_x6 got=%0b/%0d/%0h exp=1/6/66", rf_we, rf_wr, rf_wd); end
    total++; if (aux_ready !== 1'b1) begin bad++; $display("FAIL prio_ready_again got=%0b exp=1", aux_ready); end
    tick();
    aux_valid = 1'b0;
    total++; if ({rf_we, rf_wr, rf_wd, aux_count} !== {1'b1, 5'd7, 32'h77, 2'd1}) begin bad++; $display("FAIL prio_x7 got=%0b/%0d/%0h/%0d exp=1/7/77/1", rf_we, rf_wr, rf_wd, aux_count); end
    tick();
    total++; if ({rf_we, rf_wr, rf_wd, aux_count} !== {1'b1, 5'd8, 32'h88, 2'd0}) begin bad++; $display("FAIL prio_x8 got=%0b/%0d/%0h/%0d exp=1/8/88/0", rf_we, rf_wr, rf_wd, aux_count); end
    idle_inputs();
    tick();
  endtask

  task automatic test_kill();
    aux_valid = 1'b1; aux_wr = 5'd9; aux_wd = 32'hAA;
    tick();
    aux_valid = 1'b0;
    total++; if (pend_mask !== 32'h200) begin bad++; $display("FAIL kill_mask_pre got=%0h exp=200", pend_mask); end
    pipe_we = 1'b1; pipe_wr = 5'd9; pipe_wd = 32'hBB;
    tick();
    pipe_we = 1'b0;
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd9, 32'hBB}) begin bad++; $display("FAIL kill_pipe got=%0b/%0d/%0h exp=1/9/bb", rf_we, rf_wr, rf_wd); end
    total++; if ({pend_mask, aux_count} !== {32'h0, 2'd1}) begin bad++; $display("FAIL kill_dead got=%0h/%0d exp=0/1", pend_mask, aux_count); end
    tick();
    total++; if ({rf_we, rf_wd, aux_count} !== {1'b0, 32'hBB, 2'd0}) begin bad++; $display("FAIL kill_pop got=%0b/%0h/%0d exp=0/bb/0", rf_we, rf_wd, aux_count); end
    // younger same-cycle request to the written register survives
    pipe_we = 1'b1; pipe_wr = 5'd10; pipe_wd = 32'hCC;
    aux_valid = 1'b1; aux_wr = 5'd10; aux_wd = 32'hDD;
    tick();
    idle_inputs();
    total++; if (pend_mask !== 32'h400) begin bad++; $display("FAIL kill_young_mask got=%0h exp=400", pend_mask); end
    tick();
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd10, 32'hDD}) begin bad++; $display("FAIL kill_young_issue got=%0b/%0d/%0h exp=1/10/dd", rf_we, rf_wr, rf_wd); end
    tick();
  endtask

  task automatic test_starvation();
    pipe_we = 1'b1; pipe_wr = 5'd1; pipe_wd = 32'h11;
    aux_valid = 1'b1; aux_wr = 5'd3; aux_wd = 32'h33;
    tick();
    aux_valid = 1'b0;
    for (int u = 1; u <= 11; u++) begin
      tick();
      total++;
      if (stall_req !== (u >= 8)) begin bad++; $display("FAIL starve_u%0d got=%0b exp=%0b", u, stall_req, (u >= 8)); end
    end
    pipe_we = 1'b0;
    tick();
    total++; if ({rf_we, rf_wr, rf_wd} !== {1'b1, 5'd3, 32'h33}) begin bad++; $display("FAIL starve_issue got=%0b/%0d/%0h exp=1/3/33", rf_we, rf_wr, rf_wd); end
    total++; if (stall_req !== 1'b0) begin bad++; $display("FAIL starve_clear got=%0b exp=0", stall_req); end
    tick();
  endtask

  task automatic test_x0_filter();
    pipe_we = 1'b1; pipe_wr = 5'd0; pipe_wd = 32'hEE;
    aux_valid = 1'b1; aux_wr = 5'd0; aux_wd = 32'hFF;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({rf_we, aux_count} !== {1'b0, 2'd0}) begin bad++; $display("FAIL x0_c%0d got=%0b/%0d exp=0/0", c, rf_we, aux_count); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid_drain();
    pipe_we = 1'b1; pipe_wr = 5'd2; pipe_wd = 32'h22;
    aux_valid = 1'b1; aux_wr = 5'd4; aux_wd = 32'h44;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if ({rf_we, aux_count, pend_mask} !== {1'b0, 2'd0, 32'h0}) begin bad++; $display("FAIL rst_mid got=%0b/%0d/%0h exp=0/0/0", rf_we, aux_count, pend_mask); end
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL rst_mid_nodrain got=%0b exp=0", rf_we); end
  endtask

  initial begin
    test_reset();
    test_idle_drain();
    test_priority_full();
    test_kill();
    test_starvation();
    test_x0_filter();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
